// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction/data memory arbiter.
// Holds the arbiter FSM state encoding, the transaction owner type, and the
// default timeout applied while waiting for the memory to acknowledge.
package mips_pkg;

  // Default number of cycles mem_req may stay high without an ack.
  localparam int TIMEOUT_DEFAULT = 15;

  // Width of the timeout counter; wide enough for any limit in 1..255.
  localparam int ARB_TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mips_arb_timer.sv
// Timeout counter for the memory arbiter.
// Counts cycles in which a memory command is outstanding without an ack.
// expired is combinational: it is high in the cycle whose count would reach
// limit, so the owner can retire the command on that same clock edge.
module mips_arb_timer
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [ARB_TIMER_W-1:0] limit,
  output logic                   expired
);

  logic [ARB_TIMER_W-1:0] r_count;
  logic [ARB_TIMER_W:0]   w_next;

  // One extra bit keeps the compare correct even at the top of the range.
  assign w_next  = {1'b0, r_count} + {{ARB_TIMER_W{1'b0}}, 1'b1};
  assign expired = enable && (w_next >= {1'b0, limit});

  // Count waiting cycles; cleared whenever a new transaction is granted.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_next[ARB_TIMER_W-1:0];
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (if_*)
// and load/store (dm_*) requesters. One transaction is outstanding at a time:
// grant, then a registered memory command held until ack or timeout, then a
// one-cycle completion pulse to the owner.
// Build option: define MIPS_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests (dm first after reset); otherwise dm always wins.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // Load/store port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  // Memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  // Timed-out completion flag
  output logic              err
);

  localparam logic [ARB_TIMER_W-1:0] LP_LIMIT = ARB_TIMER_W'(TIMEOUT);

  arb_state_t        r_state;
  owner_t            r_owner;
  logic              r_if_gnt;
  logic              r_dm_gnt;
  logic              r_if_valid;
  logic              r_dm_valid;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic w_busy;
  logic w_grant_dm;
  logic w_timer_clr;
  logic w_timer_en;
  logic w_expired;

  assign w_busy = (r_state == BUSY_IF) || (r_state == BUSY_DM);

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  logic r_last_dm;

  // Remember which requester won the most recent grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_dm <= 1'b0;
    end else if ((r_state == IDLE) && (if_req || dm_req)) begin
      r_last_dm <= w_grant_dm;
    end
  end

  // On a tie, the side that did not win last time goes first.
  assign w_grant_dm = dm_req && (!if_req || !r_last_dm);
`else
  assign w_grant_dm = dm_req;
`endif

  // Wait cycles only accrue while the command is actually on the bus.
  assign w_timer_clr = (r_state == IDLE);
  assign w_timer_en  = w_busy && r_mem_req && !mem_ack;

  mips_arb_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_timer_clr),
    .enable  (w_timer_en),
    .limit   (LP_LIMIT),
    .expired (w_expired)
  );

  // Arbitration FSM with registered grant, command and completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      // NOTE: pulse outputs default low each cycle so they can only ever be
      // one cycle wide, whichever branch below runs.
      r_if_gnt   <= 1'b0;
      r_dm_gnt   <= 1'b0;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_err      <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            r_dm_gnt    <= 1'b1;
            r_owner     <= OWN_DM;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_state     <= BUSY_DM;
          end else if (if_req) begin
            r_if_gnt    <= 1'b1;
            r_owner     <= OWN_IF;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_state     <= BUSY_IF;
          end
        end

        BUSY_IF, BUSY_DM: begin
          if (!r_mem_req) begin
            // First busy cycle: put the latched command on the bus.
            r_mem_req <= 1'b1;
          end else if (mem_ack) begin
            // An ack wins over a simultaneous timeout.
            r_mem_req <= 1'b0;
            r_state   <= RESP;
            if (!r_mem_we) begin
              if (r_owner == OWN_DM) r_dm_rdata <= mem_rdata;
              else                   r_if_rdata <= mem_rdata;
            end
            r_if_valid <= (r_owner == OWN_IF);
            r_dm_valid <= (r_owner == OWN_DM);
          end else if (w_expired) begin
            r_mem_req <= 1'b0;
            r_state   <= RESP;
            if (r_owner == OWN_DM) r_dm_rdata <= '0;
            else                   r_if_rdata <= '0;
            r_if_valid <= (r_owner == OWN_IF);
            r_dm_valid <= (r_owner == OWN_DM);
            r_err      <= 1'b1;
          end
        end

        RESP: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign dm_gnt    = r_dm_gnt;
  assign dm_valid  = r_dm_valid;
  assign dm_rdata  = r_dm_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for mem_ack (range 1..255).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_req / if_addr  input  1 / ADDR_W  instruction-fetch request and address.
REQ-007 if_gnt / if_valid  output  1 / 1  fetch granted pulse / fetch data-valid pulse.
REQ-008 if_rdata  output  DATA_W  fetched instruction word.
REQ-009 dm_req / dm_we / dm_addr / dm_wdata  input  1 / 1 / ADDR_W / DATA_W  load/store request, write enable, address, store data.
REQ-010 dm_gnt / dm_valid / dm_rdata  output  1 / 1 / DATA_W  data grant pulse, completion pulse, load data.
REQ-011 mem_req / mem_we / mem_addr / mem_wdata  output  1 / 1 / ADDR_W / DATA_W  single-port memory command.
REQ-012 mem_ack / mem_rdata  input  1 / DATA_W  memory completion and read data.
REQ-013 err  output  1  pulses with the valid of a timed-out transaction.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-015 In IDLE, a pending request SHALL be granted: gnt pulses one cycle; address, we and wdata latched; next state BUSY_IF or BUSY_DM.
REQ-016 mem_req SHALL be registered, asserted from the cycle after grant, and held with constant command until mem_ack or timeout.
REQ-017 On mem_ack in BUSY_x: mem_rdata captured into x_rdata (loads and fetches only; stores leave x_rdata unchanged), mem_req deasserts the next cycle, state goes to RESP.
REQ-018 RESP SHALL pulse the owner's x_valid for exactly one cycle, then return to IDLE; the minimum request-to-valid latency is 3 cycles with a same-cycle ack.
REQ-019 Requesters hold req until x_valid; req deasserting before valid SHALL NOT abort the memory transaction.
REQ-020 The timeout counter SHALL clear at grant and increment each BUSY cycle without ack; on reaching TIMEOUT it SHALL drop mem_req, force x_rdata to 0, and enter RESP with err pulsed alongside x_valid.
REQ-021 An ack in the same cycle as the timeout SHALL count as success (err=0).
REQ-022 mem_ack outside BUSY states SHALL be ignored.
REQ-023 Requests arriving in BUSY/RESP SHALL wait; no queuing beyond one outstanding transaction.

Reset
REQ-024 Reset SHALL force IDLE, timer 0, and all outputs (gnt, valid, err, mem_req, mem_we, mem_addr, mem_wdata, x_rdata) to 0 immediately.
REQ-025 Reset mid-transaction SHALL abandon it silently; no valid or err after release.

Configuration
REQ-026 Macro MIPS_ARB_ROUND_ROBIN_EN: when defined, simultaneous if_req and dm_req SHALL be granted to the requester not granted last (initial winner after reset: dm).
REQ-027 Without it, dm_req SHALL always win over if_req (fixed priority).

Structure
REQ-028 Shared package mips_pkg SHALL hold the arb_state_t enum (IDLE, BUSY_IF, BUSY_DM, RESP), the owner typedef (OWN_IF, OWN_DM), and the TIMEOUT default constant.
REQ-029 Sub-module mips_arb_timer (clear, enable, limit, expired) SHALL implement the timeout counter.

Verification
REQ-030 Fetch only: if_req, if_addr=0x3; ack 2 cycles after mem_req with rdata 0x01422000 -> if_gnt 1 cycle, mem_addr=0x3, if_valid one cycle with if_rdata=0x01422000, err=0.
REQ-031 Store: dm_we=1, dm_addr=0x10, dm_wdata=0xCAFEF00D, immediate ack -> mem_we=1, mem_wdata=0xCAFEF00D, dm_valid 3 cycles after request.
REQ-032 Simultaneous if_req and dm_req, repeated 4 times -> fixed: dm,dm,dm,dm; with MIPS_ARB_ROUND_ROBIN_EN: dm,if,dm,if.
REQ-033 Timeout: TIMEOUT=4, never ack -> mem_req high exactly 4 cycles, then dm_valid with err=1 and dm_rdata=0.
REQ-034 Reset asserted while BUSY_IF -> mem_req=0 asynchronously; no if_valid after reset release; a new dm request completes normally.
REQ-035 Spurious mem_ack in IDLE -> no valid or state change.
